// File: rtl/dmem_pkg.sv
// Shared address map and register bit positions for dmem_responder.
package dmem_pkg;

    localparam int unsigned MMIO_BIT = 31;

    localparam logic [7:0] OFF_CON_DATA  = 8'h00;
    localparam logic [7:0] OFF_CON_STAT  = 8'h04;
    localparam logic [7:0] OFF_TIME_LO   = 8'h08;
    localparam logic [7:0] OFF_TIME_HI   = 8'h0C;
    localparam logic [7:0] OFF_TIME_CTRL = 8'h10;

    localparam int unsigned STAT_FULL    = 0;
    localparam int unsigned STAT_EMPTY   = 1;
    localparam int unsigned STAT_OVF     = 2;
    localparam int unsigned STAT_CNT_LSB = 8;
    localparam int unsigned STAT_CNT_W   = 8;

    localparam int unsigned CTRL_EN  = 0;
    localparam int unsigned CTRL_CLR = 1;

endpackage

// File: rtl/dmem_con_fifo.sv
// Console TX FIFO with a registered head so tx_valid/tx_data come straight from flops.
// A push into a full FIFO is accepted when the head is popped in the same cycle.
module dmem_con_fifo #(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [7:0]                    push_data,
    input  logic                          pop_ready,
    output logic                          tx_valid,
    output logic [7:0]                    tx_data,
    output logic                          full_c,
    output logic                          empty_c,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          drop_c
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr_n;
    logic [PW-1:0] rd_ptr_n;
    logic [CW-1:0] count_n;
    logic          pop;
    logic          push_acc;
    logic          valid_n;
    logic [7:0]    head_n;

    assign full_c  = (count == CW'(FIFO_DEPTH));
    assign empty_c = (count == '0);
    assign drop_c  = push && full_c && !pop;

    // Next pointers/count, and the byte that will sit at the head after this edge.
    always_comb begin
        pop      = tx_valid && pop_ready;
        push_acc = push && (!full_c || pop);
        rd_ptr_n = pop      ? rd_ptr + PW'(1) : rd_ptr;
        wr_ptr_n = push_acc ? wr_ptr + PW'(1) : wr_ptr;
        case ({push_acc, pop})
            2'b10:   count_n = count + CW'(1);
            2'b01:   count_n = count - CW'(1);
            default: count_n = count;
        endcase
        valid_n = (count_n != '0);
        head_n  = 8'h00;
        if (valid_n) begin
            // Only a push into an otherwise-empty queue lands on the new head slot.
            head_n = (push_acc && (wr_ptr == rd_ptr_n)) ? push_data : mem[rd_ptr_n];
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            wr_ptr   <= wr_ptr_n;
            rd_ptr   <= rd_ptr_n;
            count    <= count_n;
            tx_valid <= valid_n;
            tx_data  <= head_n;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-port responder: byte-lane RAM, console TX FIFO and MMIO registers, 1-cycle read latency.
// Define DMEM_TIMER_EN to add the 64-bit cycle timer at TIME_LO/TIME_HI/TIME_CTRL.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_we,
    input  logic [31:0] d_wr_data,
    output logic [31:0] d_rd_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);

    import dmem_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   ram [DEPTH_WORDS];
    logic [AW-1:0] ram_idx;
    logic          is_mmio;
    logic [7:0]    mmio_off;
    logic          con_push;
    logic          stat_clr;
    logic          overflow;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_drop;
    logic [CW-1:0] fifo_count;
    logic [31:0]   rd_mux;
    logic          unused_addr;

    assign is_mmio     = d_addr[MMIO_BIT];
    assign mmio_off    = d_addr[7:0];
    assign ram_idx     = d_addr[AW+1:2];
    assign unused_addr = ^d_addr;
    assign con_push    = is_mmio && (mmio_off == OFF_CON_DATA) && d_we[0];
    assign stat_clr    = is_mmio && (mmio_off == OFF_CON_STAT) && d_we[0] && d_wr_data[STAT_OVF];

    // RAM writes land at the edge; the read mux below sees the pre-write word.
    always_ff @(posedge clk) begin
        if (!is_mmio) begin
            for (int i = 0; i < 4; i++) begin
                if (d_we[i]) begin
                    ram[ram_idx][8*i +: 8] <= d_wr_data[8*i +: 8];
                end
            end
        end
    end

    dmem_con_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_con_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (con_push),
        .push_data (d_wr_data[7:0]),
        .pop_ready (tx_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .full_c    (fifo_full),
        .empty_c   (fifo_empty),
        .count     (fifo_count),
        .drop_c    (fifo_drop)
    );

`ifdef DMEM_TIMER_EN
    logic [63:0] timer;
    logic [63:0] timer_n;
    logic        timer_en;
    logic        lo_wr;
    logic        hi_wr;
    logic        ctrl_wr;

    assign lo_wr   = is_mmio && (mmio_off == OFF_TIME_LO) && (d_we != 4'h0);
    assign hi_wr   = is_mmio && (mmio_off == OFF_TIME_HI) && (d_we != 4'h0);
    assign ctrl_wr = is_mmio && (mmio_off == OFF_TIME_CTRL) && d_we[0];

    // Priority: clear, then byte load, then increment.
    always_comb begin
        timer_n = timer_en ? timer + 64'd1 : timer;
        if (lo_wr || hi_wr) begin
            timer_n = timer;
            for (int i = 0; i < 4; i++) begin
                if (lo_wr && d_we[i]) timer_n[8*i +: 8]      = d_wr_data[8*i +: 8];
                if (hi_wr && d_we[i]) timer_n[32 + 8*i +: 8] = d_wr_data[8*i +: 8];
            end
        end
        if (ctrl_wr && d_wr_data[CTRL_CLR]) begin
            timer_n = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer    <= '0;
            timer_en <= 1'b1;
        end else begin
            timer <= timer_n;
            if (ctrl_wr) begin
                timer_en <= d_wr_data[CTRL_EN];
            end
        end
    end
`endif

    // Side-effect-free read decode of the current address.
    always_comb begin
        rd_mux = '0;
        if (!is_mmio) begin
            rd_mux = ram[ram_idx];
        end else begin
            case (mmio_off)
                OFF_CON_STAT: begin
                    rd_mux[STAT_FULL]                     = fifo_full;
                    rd_mux[STAT_EMPTY]                    = fifo_empty;
                    rd_mux[STAT_OVF]                      = overflow;
                    rd_mux[STAT_CNT_LSB +: STAT_CNT_W]    = STAT_CNT_W'(fifo_count);
                end
`ifdef DMEM_TIMER_EN
                OFF_TIME_LO:   rd_mux = timer[31:0];
                OFF_TIME_HI:   rd_mux = timer[63:32];
                OFF_TIME_CTRL: rd_mux[CTRL_EN] = timer_en;
`endif
                default: rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_rd_data <= '0;
            overflow  <= 1'b0;
        end else begin
            d_rd_data <= rd_mux;
            if (fifo_drop) begin
                overflow <= 1'b1;
            end else if (stat_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized traffic
// against a queue/associative-array reference model.
module tb_dmem_responder;

    localparam int unsigned DEPTH_WORDS = 4096;
    localparam int unsigned FD          = 16;
    localparam logic [31:0] MMIO        = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] d_addr;
    logic [3:0]  d_we;
    logic [31:0] d_wr_data;
    logic [31:0] d_rd_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    // Reference model state
    logic [31:0] mram [int];
    logic [7:0]  q [$];
    logic [7:0]  drained [$];
    bit          ovf;
    logic [63:0] tcnt;
    bit          ten;

    int checks = 0;
    int errors = 0;

    dmem_responder #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .FIFO_DEPTH (FD),
        .INIT_FILE  ("")
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .d_addr    (d_addr),
        .d_we      (d_we),
        .d_wr_data (d_wr_data),
        .d_rd_data (d_rd_data),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] r;
        int          idx;
        r = '0;
        if (!a[31]) begin
            idx = int'((a >> 2) % DEPTH_WORDS);
            if (mram.exists(idx)) r = mram[idx];
        end else begin
            case (a[7:0])
                8'h04: begin
                    r[0]    = (q.size() == FD);
                    r[1]    = (q.size() == 0);
                    r[2]    = ovf;
                    r[15:8] = 8'(q.size());
                end
`ifdef DMEM_TIMER_EN
                8'h08: r = tcnt[31:0];
                8'h0C: r = tcnt[63:32];
                8'h10: r = {31'd0, ten};
`endif
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    // One clock: present inputs, advance the model by one edge, compare outputs.
    task automatic step(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                        input logic rdy, input bit chk_rd);
        logic [31:0] exp_rd;
        logic [31:0] w;
        logic [63:0] nxt;
        int          pre;
        int          idx;
        bit          pop;
        bit          set_ovf;
        d_addr    = a;
        d_we      = we;
        d_wr_data = wd;
        tx_ready  = rdy;
        exp_rd    = model_read(a);
        pre       = q.size();
        pop       = (pre > 0) && rdy;
        @(posedge clk);
        #1;
        set_ovf = 1'b0;
        if (pop) drained.push_back(q.pop_front());
        if (a[31]) begin
            if (a[7:0] == 8'h00 && we[0]) begin
                if (pre < FD || pop) q.push_back(wd[7:0]);
                else set_ovf = 1'b1;
            end
            if (set_ovf) ovf = 1'b1;
            else if (a[7:0] == 8'h04 && we[0] && wd[2]) ovf = 1'b0;
        end else if (we != 4'h0) begin
            idx = int'((a >> 2) % DEPTH_WORDS);
            w   = mram.exists(idx) ? mram[idx] : 32'h0;
            for (int i = 0; i < 4; i++) if (we[i]) w[8*i +: 8] = wd[8*i +: 8];
            mram[idx] = w;
        end
`ifdef DMEM_TIMER_EN
        nxt = ten ? tcnt + 64'd1 : tcnt;
        if (a[31] && we != 4'h0 && (a[7:0] == 8'h08 || a[7:0] == 8'h0C)) begin
            nxt = tcnt;
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    if (a[7:0] == 8'h08) nxt[8*i +: 8] = wd[8*i +: 8];
                    else                 nxt[32 + 8*i +: 8] = wd[8*i +: 8];
                end
            end
        end
        if (a[31] && a[7:0] == 8'h10 && we[0]) begin
            ten = wd[0];
            if (wd[1]) nxt = '0;
        end
        tcnt = nxt;
`else
        nxt = '0;
`endif
        if (chk_rd) check("rd_data", d_rd_data, exp_rd);
        check("tx_valid", 32'(tx_valid), 32'(q.size() != 0));
        if (q.size() != 0) check("tx_data", 32'(tx_data), 32'(q[0]));
    endtask

    task automatic do_reset(input int n);
        rst       = 1'b1;
        d_addr    = '0;
        d_we      = '0;
        d_wr_data = '0;
        tx_ready  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        ovf  = 1'b0;
        tcnt = '0;
        ten  = 1'b1;
    endtask

    logic [7:0]  offs [8];
    logic [31:0] ra;
    logic [3:0]  rwe;
    int          sel;

    initial begin
        offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h40, 8'hFC};

        // Reset state
        do_reset(3);
        check("reset rd_data", d_rd_data, 32'h0);
        check("reset tx_valid", 32'(tx_valid), 32'h0);
        check("reset tx_data", 32'(tx_data), 32'h0);

        // T1: full-word write then read one cycle later
        step(32'h100, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0);
        step(32'h100, 4'h0, 32'h0, 1'b0, 1'b1);
        check("T1 word", d_rd_data, 32'hDEADBEEF);

        // T2: byte write, same-cycle read returns old data, next read new data
        step(32'h101, 4'b0010, 32'h0000AA00, 1'b0, 1'b1);
        check("T2 same-cycle", d_rd_data, 32'hDEADBEEF);
        step(32'h100, 4'h0, 32'h0, 1'b0, 1'b1);
        check("T2 byte", d_rd_data, 32'hDEADAAEF);

        // T3: 17 pushes with sink stalled -> full + overflow, then drain in order
        for (int i = 0; i <= 16; i++) step(MMIO, 4'h1, 32'(i), 1'b0, 1'b1);
        step(MMIO | 32'h04, 4'h0, 32'h0, 1'b0, 1'b1);
        check("T3 stat full", d_rd_data, 32'h00001005);
        drained.delete();
        for (int i = 0; i < 16; i++) step(MMIO | 32'h04, 4'h0, 32'h0, 1'b1, 1'b1);
        check("T3 drain count", 32'(drained.size()), 32'd16);
        for (int i = 0; i < 16 && i < drained.size(); i++) check("T3 order", 32'(drained[i]), 32'(i));
        step(MMIO | 32'h04, 4'h0, 32'h0, 1'b1, 1'b1);
        check("T3 stat empty", d_rd_data, 32'h00000006);
        step(MMIO | 32'h04, 4'h1, 32'h4, 1'b0, 1'b1);
        step(MMIO | 32'h04, 4'h0, 32'h0, 1'b0, 1'b1);
        check("T3 ovf clear", d_rd_data, 32'h00000002);

        // T4: push into full FIFO while popping -> accepted, no overflow
        for (int i = 0; i < 16; i++) step(MMIO, 4'h1, $urandom, 1'b0, 1'b1);
        step(MMIO, 4'h1, 32'h55, 1'b1, 1'b1);
        step(MMIO | 32'h04, 4'h0, 32'h0, 1'b0, 1'b1);
        check("T4 stat", d_rd_data, 32'h00001001);
        drained.delete();
        for (int i = 0; i < 16; i++) step(MMIO | 32'h04, 4'h0, 32'h0, 1'b1, 1'b1);
        check("T4 drain count", 32'(drained.size()), 32'd16);
        if (drained.size() > 0) check("T4 last byte", 32'(drained[drained.size()-1]), 32'h55);

        // T5: reset with bytes queued and sink stalled
        for (int i = 0; i < 3; i++) step(MMIO, 4'h1, 32'hA0 + 32'(i), 1'b0, 1'b1);
        check("T5 pre valid", 32'(tx_valid), 32'h1);
        do_reset(1);
        check("T5 tx_valid", 32'(tx_valid), 32'h0);
        check("T5 rd_data", d_rd_data, 32'h0);
        step(MMIO | 32'h04, 4'h0, 32'h0, 1'b0, 1'b1);
        check("T5 stat", d_rd_data, 32'h00000002);
        step(32'h100, 4'h0, 32'h0, 1'b0, 1'b1);
        check("T5 ram kept", d_rd_data, 32'hDEADAAEF);

        // T6: timer
`ifdef DMEM_TIMER_EN
        step(MMIO | 32'h10, 4'h1, 32'h3, 1'b0, 1'b1);
        for (int i = 0; i < 100; i++) step(MMIO | 32'h08, 4'h0, 32'h0, 1'b0, 1'b1);
        check("T6 time_lo", d_rd_data, 32'd99);
        step(MMIO | 32'h08, 4'hF, 32'hFFFFFFFF, 1'b0, 1'b1);
        step(MMIO | 32'h0C, 4'h0, 32'h0, 1'b0, 1'b1);
        check("T6 hi before", d_rd_data, 32'h0);
        step(MMIO | 32'h0C, 4'h0, 32'h0, 1'b0, 1'b1);
        check("T6 hi wrap", d_rd_data, 32'h1);
`else
        step(MMIO | 32'h08, 4'hF, 32'h12345678, 1'b0, 1'b1);
        step(MMIO | 32'h08, 4'h0, 32'h0, 1'b0, 1'b1);
        check("T6 time_lo off", d_rd_data, 32'h0);
`endif

        // Randomized traffic over a prefilled RAM window, aliases and MMIO
        for (int k = 0; k < 16; k++) step(32'h200 + 32'(k) * 4, 4'hF, $urandom, 1'b0, 1'b0);
        for (int n = 0; n < 400; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 4) begin
                ra        = 32'h200 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
                ra[30:14] = 17'($urandom);
                rwe       = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            end else begin
                ra       = MMIO;
                ra[30:8] = 23'($urandom);
                ra[7:0]  = offs[$urandom_range(0, 7)];
                if (ra[7:0] == 8'h00) rwe = ($urandom_range(0, 1) == 1) ? 4'h1 : 4'h0;
                else                  rwe = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            end
            step(ra, rwe, $urandom, 1'($urandom), 1'b1);
        end

        // Read-only sweep: nothing may change state
        for (int i = 0; i < 64; i++) step(MMIO + 32'(i) * 4, 4'h0, $urandom, 1'b0, 1'b1);
        for (int k = 0; k < 16; k++) step(32'h200 + 32'(k) * 4, 4'h0, $urandom, 1'b0, 1'b1);
        step(MMIO | 32'h04, 4'h0, 32'h0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
